// File: rtl/multi_dose_scheduler.sv
// N-slot medicine dose scheduler: per-slot countdown, due/grace/missed
// tracking and a zero-latency display mux for one selected slot.
module multi_dose_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int ID_W      = 4,
  parameter int INT_W     = 8,
  parameter int TICK_DIV  = 50_000_000,
  parameter int GRACE     = 3,
  parameter int MISS_W    = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Prog_Valid,
  input  logic [3:0]           Prog_Slot,
  input  logic [ID_W-1:0]      Prog_MedID,
  input  logic [INT_W-1:0]     Prog_Interval,
  input  logic                 Ack_Valid,
  input  logic [3:0]           Ack_Slot,
  input  logic [3:0]           Disp_Slot,
  output logic [NUM_SLOTS-1:0] Due_Led,
  output logic [NUM_SLOTS-1:0] Missed_Led,
  output logic                 Alarm,
  output logic                 Prog_Err,
  output logic                 Ack_Err,
  output logic [ID_W-1:0]      Disp_MedID,
  output logic [INT_W-1:0]     Disp_TimeRem,
  output logic [MISS_W-1:0]    Disp_Missed
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam int GR_C = $clog2(GRACE + 1);
  localparam int GR_W = (GR_C > 2) ? GR_C : 2;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
  localparam logic [GR_W-1:0] GR_INIT = GR_W'(GRACE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DUE,
    ST_MISSED
  } state_e;

  state_e              st_q   [NUM_SLOTS];
  state_e              st_d   [NUM_SLOTS];
  logic [ID_W-1:0]     med_q  [NUM_SLOTS];
  logic [ID_W-1:0]     med_d  [NUM_SLOTS];
  logic [INT_W-1:0]    intv_q [NUM_SLOTS];
  logic [INT_W-1:0]    intv_d [NUM_SLOTS];
  logic [INT_W-1:0]    rem_q  [NUM_SLOTS];
  logic [INT_W-1:0]    rem_d  [NUM_SLOTS];
  logic [GR_W-1:0]     gr_q   [NUM_SLOTS];
  logic [GR_W-1:0]     gr_d   [NUM_SLOTS];
  logic [MISS_W-1:0]   miss_q [NUM_SLOTS];
  logic [MISS_W-1:0]   miss_d [NUM_SLOTS];

  logic [PS_W-1:0] ps_q, ps_d;
  logic            prog_err_q, prog_err_d;
  logic            ack_err_q, ack_err_d;
  logic            tick;
  logic            prog_in;
  logic            ack_ok;

  always_comb begin
    tick    = (ps_q == PS_MAX);
    ps_d    = tick ? '0 : ps_q + PS_W'(1);
    prog_in = {1'b0, Prog_Slot} < 5'(NUM_SLOTS);
    ack_ok  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (Ack_Slot == 4'(i) &&
          (st_q[i] == ST_DUE || st_q[i] == ST_MISSED))
        ack_ok = 1'b1;
    end
    prog_err_d = Prog_Valid && !prog_in;
    ack_err_d  = Ack_Valid && !ack_ok;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      st_d[i]   = st_q[i];
      med_d[i]  = med_q[i];
      intv_d[i] = intv_q[i];
      rem_d[i]  = rem_q[i];
      gr_d[i]   = gr_q[i];
      miss_d[i] = miss_q[i];
      // Program beats ack beats tick on the same slot
      if (Prog_Valid && Prog_Slot == 4'(i)) begin
        if (Prog_Interval == '0) begin
          st_d[i]   = ST_IDLE;
          med_d[i]  = '0;
          intv_d[i] = '0;
          rem_d[i]  = '0;
          gr_d[i]   = '0;
          miss_d[i] = '0;
        end else begin
          st_d[i]   = ST_COUNT;
          med_d[i]  = Prog_MedID;
          intv_d[i] = Prog_Interval;
          rem_d[i]  = Prog_Interval;
          gr_d[i]   = '0;
          miss_d[i] = '0;
        end
      end else if (Ack_Valid && Ack_Slot == 4'(i) &&
                   (st_q[i] == ST_DUE ||
                    st_q[i] == ST_MISSED)) begin
        st_d[i]  = ST_COUNT;
        rem_d[i] = intv_q[i];
        gr_d[i]  = '0;
      end else if (tick) begin
        case (st_q[i])
          ST_COUNT: begin
            if (rem_q[i] > INT_W'(1)) begin
              rem_d[i] = rem_q[i] - INT_W'(1);
            end else begin
              st_d[i]  = ST_DUE;
              rem_d[i] = '0;
              gr_d[i]  = GR_INIT;
            end
          end
          ST_DUE: begin
            if (gr_q[i] > GR_W'(1)) begin
              gr_d[i] = gr_q[i] - GR_W'(1);
            end else begin
              st_d[i] = ST_MISSED;
              gr_d[i] = '0;
              if (miss_q[i] != '1)
                miss_d[i] = miss_q[i] + MISS_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ps_q       <= '0;
      prog_err_q <= 1'b0;
      ack_err_q  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]   <= ST_IDLE;
        med_q[i]  <= '0;
        intv_q[i] <= '0;
        rem_q[i]  <= '0;
        gr_q[i]   <= '0;
        miss_q[i] <= '0;
      end
    end else begin
      ps_q       <= ps_d;
      prog_err_q <= prog_err_d;
      ack_err_q  <= ack_err_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]   <= st_d[i];
        med_q[i]  <= med_d[i];
        intv_q[i] <= intv_d[i];
        rem_q[i]  <= rem_d[i];
        gr_q[i]   <= gr_d[i];
        miss_q[i] <= miss_d[i];
      end
    end
  end

  always_comb begin
    Due_Led      = '0;
    Missed_Led   = '0;
    Disp_MedID   = '0;
    Disp_TimeRem = '0;
    Disp_Missed  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      Due_Led[i]    = (st_q[i] == ST_DUE);
      Missed_Led[i] = (st_q[i] == ST_MISSED);
      if (Disp_Slot == 4'(i)) begin
        Disp_MedID  = med_q[i];
        Disp_Missed = miss_q[i];
        if (st_q[i] == ST_COUNT)
          Disp_TimeRem = rem_q[i];
      end
    end
    Alarm    = (|Due_Led) | (|Missed_Led);
    Prog_Err = prog_err_q;
    Ack_Err  = ack_err_q;
  end

endmodule

// File: doc/multi_dose_scheduler.md
# multi_dose_scheduler

Parametrised N-slot medicine scheduler: each slot holds a medicine ID and a dosing interval, counts down in prescaled time units, raises a due indication, and escalates to missed if not acknowledged within a grace window. It supersedes the single-medicine RAM/timer pairing behind the reminder top level, and feeds the green/red LED banks and the time-remaining 7-segment display.

## Interface
- NUM_SLOTS, 4, number of independent medicine slots (1..16)
- ID_W, 4, medicine ID width
- INT_W, 8, interval/time-remaining width (time units)
- TICK_DIV, 50_000_000, Clk cycles per time unit (>=2)
- GRACE, 3, time units allowed in DUE before MISSED (>=1)
- MISS_W, 4, per-slot saturating missed-dose counter width
- Clk  in  1  system clock; the only clock
- Rst  in  1  synchronous, active-high reset
- Prog_Valid  in  1  one-cycle program strobe
- Prog_Slot  in  4  slot index to program
- Prog_MedID  in  ID_W  medicine ID
- Prog_Interval  in  INT_W  dosing interval; 0 = clear slot
- Ack_Valid  in  1  one-cycle dose-taken strobe (debounced Enter_Button)
- Ack_Slot  in  4  slot acknowledged
- Disp_Slot  in  4  slot selected for display outputs
- Due_Led  out  NUM_SLOTS  bit i = slot i in DUE
- Missed_Led  out  NUM_SLOTS  bit i = slot i in MISSED
- Alarm  out  1  OR of Due_Led and Missed_Led
- Prog_Err  out  1  one-cycle pulse: Prog_Slot >= NUM_SLOTS
- Ack_Err  out  1  one-cycle pulse: ack to out-of-range slot or slot not DUE/MISSED
- Disp_MedID  out  ID_W  MedID of Disp_Slot (0 if out of range)
- Disp_TimeRem  out  INT_W  time remaining of Disp_Slot (0 if DUE/MISSED/IDLE/out of range)
- Disp_Missed  out  MISS_W  missed count of Disp_Slot

## Operation
- Prescaler: counter 0..TICK_DIV-1; internal tick is high for the one cycle in which the counter equals TICK_DIV-1, then it wraps to 0. Free-running; not affected by Prog/Ack.
- Per-slot registers: state, MedID, Interval, Rem (INT_W), Grace (2+ bits), Missed (MISS_W).
- States: IDLE, COUNTING, DUE, MISSED.
  - Program (in-range slot, Interval != 0), any state -> COUNTING; MedID/Interval stored, Rem = Interval, Missed = 0.
  - Program with Interval == 0 -> IDLE; all slot registers cleared.
  - COUNTING on tick: Rem > 1 -> Rem - 1; Rem == 1 -> DUE, Rem = 0, Grace = GRACE.
  - DUE on tick: Grace > 1 -> Grace - 1; Grace == 1 -> MISSED, Missed += 1 (saturates at all-ones).
  - MISSED: held until ack or program; ticks have no effect.
  - Ack in DUE or MISSED -> COUNTING, Rem = Interval. Missed is not cleared.
  - Ack in IDLE or COUNTING: no state change, Ack_Err pulses.
- Priority in a cycle on the same slot: Program > Ack > tick. Program and Ack to different slots both take effect; tick applies to every slot not being programmed or acked that cycle.
- Out-of-range Prog_Slot: ignored, Prog_Err pulses. Out-of-range Ack_Slot: ignored, Ack_Err pulses.
- Display outputs are a combinational mux of registered slot state indexed by Disp_Slot.

## Timing
- Reset: every slot IDLE with all registers 0; prescaler 0; Due_Led, Missed_Led, Alarm, Prog_Err, Ack_Err all 0; display outputs therefore 0.
- Reset mid-operation: takes effect on the next Clk edge and overrides Prog/Ack/tick in that cycle.
- Prog/Ack sampled on the Clk edge; new state and LEDs are visible the cycle after the strobe. Prog_Err/Ack_Err are high exactly in that cycle.
- From program to DUE: Interval ticks. The first tick after programming counts, so wall time is between (Interval-1)*TICK_DIV+1 and Interval*TICK_DIV cycles.
- DUE to MISSED: exactly GRACE ticks.
- Disp_* follow Disp_Slot in the same cycle (zero latency). They reflect register updates one cycle after the causing edge.
- Strobes held high for multiple cycles are treated as repeated events, one per cycle.

## Test plan
- Params NUM_SLOTS=4, TICK_DIV=4, GRACE=2. Reset, program slot 1 with ID 5 and Interval 3 -> next cycle Disp_Slot=1 shows MedID 5, TimeRem 3. After 3 ticks Due_Led=4'b0010 and Alarm=1.
- Same setup, no ack -> 2 ticks after DUE, Missed_Led=4'b0010, Due_Led=0, Disp_Missed=1. Ack slot 1 -> COUNTING, TimeRem 3, Missed_Led=0, Disp_Missed stays 1.
- Ack slot 1 while COUNTING -> Ack_Err pulse for 1 cycle, TimeRem unchanged. Ack slot 6 -> Ack_Err pulse. Program slot 4 -> Prog_Err pulse, no slot changes.
- Slot 0 DUE; in one cycle, Prog slot 0 with Interval 7 and Ack slot 0 -> slot 0 is COUNTING with Rem 7 (program wins). Ack slot 0 coincident with a tick while DUE -> Rem = Interval, not decremented.
- Drive missed events on slot 2 repeatedly, 20 times -> Disp_Missed saturates at 15. Program slot 2 with Interval 0 -> IDLE, Disp_MedID 0, Disp_Missed 0.
- Run with slots 0..3 in mixed states, then assert Rst for one cycle -> every output is 0 the next cycle, and the prescaler restarts (first tick 4 cycles after Rst deasserts).
